// File: rtl/tristate_bus_arbiter_if.sv
// Shared tristate bus control bundle.
// The arbiter drives enables; requesters drive levels.
interface tristate_bus_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] bus_en;
  logic [OW-1:0]      owner;
  logic               busy;

  modport master (
    input  req,
    output bus_en,
    output owner,
    output busy
  );

  modport slave (
    output req,
    input  bus_en,
    input  owner,
    input  busy
  );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tristate bus.
// Every handover is separated by a fixed idle turnaround gap.
module tristate_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  tristate_bus_arbiter_if.master bus
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURNAROUND + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [OW-1:0]      ptr_q;
  logic [OW-1:0]      ptr_d;
  logic [OW-1:0]      owner_q;
  logic [OW-1:0]      owner_d;
  logic [HW-1:0]      hold_q;
  logic [HW-1:0]      hold_d;
  logic [HW-1:0]      hold_inc;
  logic [TW-1:0]      turn_q;
  logic [TW-1:0]      turn_d;
  logic [NUM_REQ-1:0] bus_en_q;
  logic [NUM_REQ-1:0] bus_en_d;
  logic               busy_q;
  logic               busy_d;

  logic [NUM_REQ-1:0] req;
  logic               win_vld;
  logic [OW-1:0]      win_idx;
  logic [OW-1:0]      ptr_nxt;

  assign req = bus.req;

  // First set request at or above ptr, wrapping.
  always_comb begin
    int            j;
    logic [OW-1:0] jj;
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    jj      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j  = (int'(ptr_q) + i) % NUM_REQ;
      jj = OW'(j);
      if (!win_vld && req[jj]) begin
        win_vld = 1'b1;
        win_idx = jj;
      end
    end
  end

  assign ptr_nxt = (owner_q == OW'(NUM_REQ - 1))
                 ? '0
                 : owner_q + OW'(1);

  assign hold_inc = hold_q + HW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          owner_d = win_idx;
          hold_d  = '0;
        end
      end
      GRANT: begin
        // Release and hold limit share one exit.
        if (!req[owner_q] ||
            hold_inc >= HW'(MAX_HOLD)) begin
          state_d = TURN;
          turn_d  = '0;
          ptr_d   = ptr_nxt;
        end else begin
          hold_d = hold_inc;
        end
      end
      TURN: begin
        if (turn_q == TW'(TURNAROUND - 1)) begin
          if (win_vld) begin
            state_d = GRANT;
            owner_d = win_idx;
            hold_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy_d   = (state_d == GRANT);
    bus_en_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus_en_d[i] = busy_d && (owner_d == OW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      hold_q   <= '0;
      turn_q   <= '0;
      bus_en_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
      bus_en_q <= bus_en_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.bus_en = bus_en_q;
  assign bus.owner  = owner_q;
  assign bus.busy   = busy_q;
endmodule
